// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode encoding and the queued request format.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    localparam logic [2:0] ALU_OP_ILLEGAL = 3'b011;

    // op is kept as raw bits so an illegal code can still be queued and dropped later
    typedef struct packed {
        logic [2:0]           op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_req_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op != ALU_OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Show-ahead synchronous FIFO of ALU requests; the head entry is always readable.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  alu_req_t               i_data,
    input  logic                   i_pop,
    output alu_req_t               o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    alu_req_t          r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the combinational ALU: request FIFO, illegal-op drop, registered result.
// Optional ALU_ISSUE_STATS_EN adds saturating issue/zero counters.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_f,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_zero,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_zero,
    output logic [2:0]             res_op,
    output logic                   err_illegal,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]            stat_issued,
    output logic [15:0]            stat_zero
`endif
);

    localparam logic [$clog2(DEPTH):0] FULL_COUNT = DEPTH[$clog2(DEPTH):0];

    alu_req_t   w_push_req;
    alu_req_t   w_head;
    logic       w_empty;
    logic       w_head_live;
    logic       w_free;
    logic       w_push;
    logic       w_issue;
    logic       w_drop;

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_zero;
    logic [2:0]       r_res_op;
    logic             r_err_illegal;

    // WIDTH must equal ALU_WIDTH so operands map directly onto the request fields
    assign w_push_req.op = in_op;
    assign w_push_req.a  = in_a;
    assign w_push_req.b  = in_b;

    assign in_ready = (fifo_count != FULL_COUNT);
    assign w_push   = in_valid & in_ready;
    assign w_empty  = (fifo_count == '0);
    assign w_free   = ~r_res_valid | res_ready;

    assign w_head_live = ~w_empty & op_is_legal(w_head.op);
    assign w_issue     = w_head_live & w_free;
    assign w_drop      = ~w_empty & ~op_is_legal(w_head.op);

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_issue | w_drop),
        .o_head  (w_head),
        .o_count (fifo_count)
    );

    // ALU sees zeros unless a legal entry is at the head, so 011 never reaches it
    assign alu_a = w_head_live ? w_head.a  : '0;
    assign alu_b = w_head_live ? w_head.b  : '0;
    assign alu_f = w_head_live ? w_head.op : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_zero    <= 1'b0;
            r_res_op      <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            r_err_illegal <= w_drop;
            if (w_issue) begin
                r_res_valid <= 1'b1;
                r_res_data  <= alu_out;
                r_res_zero  <= alu_zero;
                r_res_op    <= w_head.op;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_zero    = r_res_zero;
    assign res_op      = r_res_op;
    assign err_illegal = r_err_illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_zero   <= '0;
        end else if (w_issue) begin
            if (r_stat_issued != '1)           r_stat_issued <= r_stat_issued + 1'b1;
            if (alu_zero && r_stat_zero != '1) r_stat_zero   <= r_stat_zero + 1'b1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_zero   = r_stat_zero;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural ALU model attached.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b000;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_f;
    logic             alu_zero;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [2:0]       res_op;
    logic             err_illegal;
    logic [2:0]       fifo_count;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]      stat_issued, stat_zero;
`endif

    int tests = 0;
    int fails = 0;
    logic saw011 = 1'b0;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .res_op(res_op), .err_illegal(err_illegal), .fifo_count(fifo_count)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_zero(stat_zero)
`endif
    );

    // Behavioural ALU: SLT is the sign bit of a-b
    logic [WIDTH-1:0] diff;
    always_comb begin
        diff = alu_a - alu_b;
        case (alu_f)
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            3'b010:  alu_out = alu_a + alu_b;
            3'b100:  alu_out = alu_a & ~alu_b;
            3'b101:  alu_out = alu_a | ~alu_b;
            3'b110:  alu_out = diff;
            3'b111:  alu_out = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    always @(negedge clk) if (alu_f === 3'b011) saw011 = 1'b1;

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    endtask

    task automatic test_reset;
        #3;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid got=%0h exp=0", res_valid); end
        tests++; if (res_data !== '0) begin fails++; $display("FAIL rst_res_data got=%0h exp=0", res_data); end
        tests++; if (res_zero !== 1'b0 || res_op !== 3'b000) begin fails++; $display("FAIL rst_res_zero_op got=%0h/%0h exp=0/0", res_zero, res_op); end
        tests++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL rst_err got=%0h exp=0", err_illegal); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        tests++; if (alu_a !== '0 || alu_b !== '0 || alu_f !== 3'b000) begin fails++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0/0/0", alu_a, alu_b, alu_f); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_add;
        res_ready = 1'b1;
        drive(ALU_ADD, 32'd5, 32'd7);
        @(posedge clk); #1; in_valid = 1'b0;
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_no_bypass got=%0h exp=0", res_valid); end
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL add_count got=%0d exp=1", fifo_count); end
        tests++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_f !== 3'b010) begin fails++; $display("FAIL add_alu_in got=%0h/%0h/%0h exp=5/7/2", alu_a, alu_b, alu_f); end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL add_valid got=%0h exp=1", res_valid); end
        tests++; if (res_data !== 32'd12) begin fails++; $display("FAIL add_data got=%0d exp=12", res_data); end
        tests++; if (res_zero !== 1'b0 || res_op !== 3'b010) begin fails++; $display("FAIL add_zero_op got=%0h/%0h exp=0/2", res_zero, res_op); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL add_count_after got=%0d exp=0", fifo_count); end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_valid_clear got=%0h exp=0", res_valid); end
    endtask

    task automatic test_back_to_back;
        res_ready = 1'b1;
        drive(ALU_SUB, 32'd9, 32'd9);
        @(posedge clk); #1;
        drive(ALU_SLT, 32'd3, 32'd8);
        @(posedge clk); #1; in_valid = 1'b0;
        tests++; if (res_valid !== 1'b1 || res_data !== 32'd0 || res_zero !== 1'b1 || res_op !== 3'b110)
            begin fails++; $display("FAIL b2b_sub got=%0h/%0h/%0h/%0h exp=1/0/1/6", res_valid, res_data, res_zero, res_op); end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b1 || res_data !== 32'd1 || res_zero !== 1'b0 || res_op !== 3'b111)
            begin fails++; $display("FAIL b2b_slt got=%0h/%0h/%0h/%0h exp=1/1/0/7", res_valid, res_data, res_zero, res_op); end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL b2b_idle got=%0h/%0d exp=0/0", res_valid, fifo_count); end
    endtask

    task automatic test_backpressure;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(ALU_ADD, 32'(i + 1), 32'd100);
            @(posedge clk); #1;
            if (i >= 1) begin
                tests++; if (res_valid !== 1'b1 || res_data !== 32'd101)
                    begin fails++; $display("FAIL bp_hold_%0d got=%0h/%0d exp=1/101", i, res_valid, res_data); end
            end
        end
        in_valid = 1'b0;
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL bp_full_count got=%0d exp=4", fifo_count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
        repeat (2) @(posedge clk); #1;
        tests++; if (res_data !== 32'd101 || res_op !== 3'b010) begin fails++; $display("FAIL bp_stable got=%0d/%0h exp=101/2", res_data, res_op); end
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            tests++; if (res_valid !== 1'b1 || res_data !== 32'(102 + j))
                begin fails++; $display("FAIL bp_drain_%0d got=%0h/%0d exp=1/%0d", j, res_valid, res_data, 102 + j); end
            if (j == 0) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got=%0h exp=1", in_ready); end
            end
        end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL bp_empty got=%0h/%0d exp=0/0", res_valid, fifo_count); end
    endtask

    task automatic test_illegal;
        logic [2:0]  ops [3];
        logic [31:0] av  [3];
        logic [31:0] bv  [3];
        logic [31:0] got [4];
        int n_err;
        int n_res;
        ops[0] = ALU_OR;         av[0] = 32'd1; bv[0] = 32'd2;
        ops[1] = ALU_OP_ILLEGAL; av[1] = 32'd5; bv[1] = 32'd5;
        ops[2] = ALU_OR;         av[2] = 32'd4; bv[2] = 32'd8;
        n_err = 0; n_res = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(ops[c], av[c], bv[c]); else in_valid = 1'b0;
            @(posedge clk); #1;
            if (err_illegal === 1'b1) n_err++;
            if (res_valid === 1'b1 && n_res < 4) begin got[n_res] = res_data; n_res++; end
            if (c == 1) begin
                tests++; if (alu_f !== 3'b000 || alu_a !== '0) begin fails++; $display("FAIL ill_head_masked got=%0h/%0h exp=0/0", alu_f, alu_a); end
            end
        end
        tests++; if (n_err != 1) begin fails++; $display("FAIL ill_err_pulses got=%0d exp=1", n_err); end
        tests++; if (n_res != 2) begin fails++; $display("FAIL ill_result_count got=%0d exp=2", n_res); end
        tests++; if (n_res >= 2 && (got[0] !== 32'd3 || got[1] !== 32'd12)) begin fails++; $display("FAIL ill_results got=%0d,%0d exp=3,12", got[0], got[1]); end
        tests++; if (saw011 !== 1'b0) begin fails++; $display("FAIL ill_alu_f_011 got=%0h exp=0", saw011); end
    endtask

    task automatic test_reset_midway;
        int seen;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ALU_ADD, 32'(20 + i), 32'd22);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (res_valid !== 1'b1 || res_data !== 32'd42 || fifo_count !== 3'd3)
            begin fails++; $display("FAIL mid_pre got=%0h/%0d/%0d exp=1/42/3", res_valid, res_data, fifo_count); end
        #2 rst = 1'b1;
        #1;
        tests++; if (res_valid !== 1'b0 || res_data !== '0 || res_zero !== 1'b0 || res_op !== 3'b000)
            begin fails++; $display("FAIL mid_rst_res got=%0h/%0h/%0h/%0h exp=0/0/0/0", res_valid, res_data, res_zero, res_op); end
        tests++; if (fifo_count !== 3'd0 || in_ready !== 1'b1 || err_illegal !== 1'b0)
            begin fails++; $display("FAIL mid_rst_fifo got=%0d/%0h/%0h exp=0/1/0", fifo_count, in_ready, err_illegal); end
        tests++; if (alu_a !== '0 || alu_b !== '0 || alu_f !== 3'b000)
            begin fails++; $display("FAIL mid_rst_alu got=%0h/%0h/%0h exp=0/0/0", alu_a, alu_b, alu_f); end
        @(posedge clk); #1; rst = 1'b0; res_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0 || err_illegal !== 1'b0 || fifo_count !== 3'd0) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_stale got=%0d exp=0", seen); end
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats;
        logic [2:0]  ops [5];
        logic [31:0] av  [5];
        logic [31:0] bv  [5];
        ops[0] = ALU_SUB; av[0] = 32'd1; bv[0] = 32'd1;
        ops[1] = ALU_SUB; av[1] = 32'd2; bv[1] = 32'd2;
        ops[2] = ALU_AND; av[2] = 32'd5; bv[2] = 32'd2;
        ops[3] = ALU_ADD; av[3] = 32'd1; bv[3] = 32'd1;
        ops[4] = ALU_OR;  av[4] = 32'd1; bv[4] = 32'd0;
        rst = 1'b1; #3; rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], av[i], bv[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        tests++; if (stat_issued !== 16'd5) begin fails++; $display("FAIL stat_issued got=%0d exp=5", stat_issued); end
        tests++; if (stat_zero !== 16'd3) begin fails++; $display("FAIL stat_zero got=%0d exp=3", stat_zero); end
        drive(ALU_ADD, 32'd1, 32'd1);
        repeat (65535) @(posedge clk);
        #1; in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        tests++; if (stat_issued !== 16'hFFFF) begin fails++; $display("FAIL stat_sat got=%0h exp=ffff", stat_issued); end
        tests++; if (stat_zero !== 16'd3) begin fails++; $display("FAIL stat_zero_hold got=%0d exp=3", stat_zero); end
    endtask
`endif

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_backpressure;
        test_illegal;
        test_reset_midway;
`ifdef ALU_ISSUE_STATS_EN
        test_stats;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
